// File: rtl/wb_regfile.sv
// MEM/WB consumer: write-back select, load extension, 32x32 register file with
// write-through bypass to the readers, and a retired-instruction counter.
module wb_regfile #(
    parameter int unsigned RET_W    = 32,
    parameter logic [31:0] LINK_OFS = 32'd4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      IR,
    input  logic [4:0]       A3,
    input  logic [31:0]      AO,
    input  logic [31:0]      DR,
    input  logic [31:0]      PCp4,
    input  logic             RegWrite,
    input  logic             MemtoReg,
    input  logic [1:0]       Link,
    input  logic             AWAY,
    input  logic [4:0]       RA1,
    input  logic [4:0]       RA2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             WB_WE,
    output logic [31:0]      WB_WD,
    output logic [RET_W-1:0] RETIRED
);

    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;

    logic [31:0]      regs_q [32];
    logic [RET_W-1:0] ret_q;
    logic [5:0]       opcode;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             unused_ir;

    assign opcode    = IR[31:26];
    assign unused_ir = ^IR[25:0];

    // Pick the addressed byte and halfword lanes (little-endian).
    always_comb begin
        ld_byte = DR[7:0];
        case (AO[1:0])
            2'd0:    ld_byte = DR[7:0];
            2'd1:    ld_byte = DR[15:8];
            2'd2:    ld_byte = DR[23:16];
            default: ld_byte = DR[31:24];
        endcase
        ld_half = AO[1] ? DR[31:16] : DR[15:0];
    end

    // Extend load data according to the load opcode; unknown opcodes pass DR through.
    always_comb begin
        ld_data = DR;
        case (opcode)
            OpLw:    ld_data = DR;
            OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_data = {24'd0, ld_byte};
            OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_data = {16'd0, ld_half};
            default: ld_data = DR;
        endcase
    end

    // Write-back select: link beats load beats ALU; Link=11 is treated as no link.
    always_comb begin
        WB_WD = AO;
        if (Link == 2'b01 || Link == 2'b10) begin
            WB_WD = PCp4 + LINK_OFS;
        end else if (MemtoReg) begin
            WB_WD = ld_data;
        end
    end

    // Cancelled instructions and writes to r0 have no effect.
    assign WB_WE = RegWrite & ~AWAY & (A3 != 5'd0);

    // Register file; r0 is never written because WB_WE excludes A3 == 0.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (WB_WE) begin
            regs_q[A3] <= WB_WD;
        end
    end

    // Read port 1 with same-cycle bypass of the write-back value.
    always_comb begin
        if (RA1 == 5'd0) begin
            RD1 = '0;
        end else if (WB_WE && RA1 == A3) begin
            RD1 = WB_WD;
        end else begin
            RD1 = regs_q[RA1];
        end
    end

    // Read port 2 with same-cycle bypass of the write-back value.
    always_comb begin
        if (RA2 == 5'd0) begin
            RD2 = '0;
        end else if (WB_WE && RA2 == A3) begin
            RD2 = WB_WD;
        end else begin
            RD2 = regs_q[RA2];
        end
    end

    // Count every non-bubble, non-cancelled instruction; wraps silently.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ret_q <= '0;
        end else if (IR != 32'd0 && !AWAY) begin
            ret_q <= ret_q + RET_W'(1);
        end
    end

    assign RETIRED = ret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: table-driven combinational vectors through a scoreboard
// queue, plus hand sequences for reset, suppression and counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic [4:0]  a3;
    logic [31:0] ao;
    logic [31:0] dr;
    logic [31:0] pcp4;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  link;
    logic        away;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_we;
    logic [31:0] wb_wd;
    logic [31:0] retired;

    logic [31:0] w_ir;
    logic [2:0]  w_retired;
    logic [31:0] unused_rd1;
    logic [31:0] unused_rd2;
    logic        unused_we;
    logic [31:0] unused_wd;

    int passed;
    int total;
    int exp_ret;

    typedef struct packed {
        logic [31:0] ir;
        logic [4:0]  a3;
        logic [31:0] ao;
        logic [31:0] dr;
        logic [31:0] pcp4;
        logic        rw;
        logic        m2r;
        logic [1:0]  link;
        logic        away;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [31:0] wd;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } exp_t;

    localparam int NumVec = 19;
    vec_t vecs [NumVec];
    exp_t sb [$];

    wb_regfile #(.RET_W(32), .LINK_OFS(32'd4)) u_dut (
        .CLK      (clk),
        .reset    (reset),
        .IR       (ir),
        .A3       (a3),
        .AO       (ao),
        .DR       (dr),
        .PCp4     (pcp4),
        .RegWrite (reg_write),
        .MemtoReg (mem_to_reg),
        .Link     (link),
        .AWAY     (away),
        .RA1      (ra1),
        .RA2      (ra2),
        .RD1      (rd1),
        .RD2      (rd2),
        .WB_WE    (wb_we),
        .WB_WD    (wb_wd),
        .RETIRED  (retired)
    );

    wb_regfile #(.RET_W(3), .LINK_OFS(32'd4)) u_wrap (
        .CLK      (clk),
        .reset    (reset),
        .IR       (w_ir),
        .A3       (5'd0),
        .AO       (32'd0),
        .DR       (32'd0),
        .PCp4     (32'd0),
        .RegWrite (1'b0),
        .MemtoReg (1'b0),
        .Link     (2'b00),
        .AWAY     (1'b0),
        .RA1      (5'd0),
        .RA2      (5'd0),
        .RD1      (unused_rd1),
        .RD2      (unused_rd2),
        .WB_WE    (unused_we),
        .WB_WD    (unused_wd),
        .RETIRED  (w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Cross one rising edge and return at the following falling edge; the
    // retire model counts what was presented at the edge.
    task automatic step();
        @(posedge clk);
        if (reset && ir != 32'd0 && !away) exp_ret++;
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        ir         = v.ir;
        a3         = v.a3;
        ao         = v.ao;
        dr         = v.dr;
        pcp4       = v.pcp4;
        reg_write  = v.rw;
        mem_to_reg = v.m2r;
        link       = v.link;
        away       = v.away;
        ra1        = v.ra1;
        ra2        = v.ra2;
    endtask

    initial begin
        exp_t e;
        passed  = 0;
        total   = 0;
        exp_ret = 0;
        w_ir    = 32'd0;

        // Fields: ir a3 ao dr pcp4 rw m2r link away ra1 ra2 | we wd rd1 rd2
        vecs[0]  = '{32'h8000_0000, 5'd8,  32'h3,         32'h80FF_7F01, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd8,  5'd0,
                     1'b1, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'h0};
        vecs[1]  = '{32'h9000_0000, 5'd8,  32'h3,         32'h80FF_7F01, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd8,  5'd8,
                     1'b1, 32'h0000_0080, 32'h0000_0080, 32'h0000_0080};
        vecs[2]  = '{32'h8400_0000, 5'd10, 32'h2,         32'h80FF_7F01, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd10, 5'd8,
                     1'b1, 32'hFFFF_80FF, 32'hFFFF_80FF, 32'h0000_0080};
        vecs[3]  = '{32'h9400_0000, 5'd11, 32'h3,         32'h80FF_7F01, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd11, 5'd10,
                     1'b1, 32'h0000_80FF, 32'h0000_80FF, 32'hFFFF_80FF};
        vecs[4]  = '{32'h8C00_0000, 5'd12, 32'h100,       32'h1234_5678, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd12, 5'd11,
                     1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_80FF};
        vecs[5]  = '{32'h8000_0000, 5'd13, 32'h4,         32'h80FF_7F01, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  5'd13,
                     1'b1, 32'h0000_0001, 32'h0,          32'h0000_0001};
        vecs[6]  = '{32'h8000_0000, 5'd14, 32'h1,         32'h80FF_7F01, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd12, 5'd14,
                     1'b1, 32'h0000_007F, 32'h1234_5678, 32'h0000_007F};
        vecs[7]  = '{32'h8400_0000, 5'd15, 32'h0,         32'h1234_8001, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd15, 5'd13,
                     1'b1, 32'hFFFF_8001, 32'hFFFF_8001, 32'h0000_0001};
        vecs[8]  = '{32'h0000_0020, 5'd16, 32'h0,         32'hCAFE_F00D, 32'h0,
                     1'b1, 1'b1, 2'b00, 1'b0, 5'd16, 5'd15,
                     1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hFFFF_8001};
        vecs[9]  = '{32'h0000_0020, 5'd17, 32'hA5A5_0003, 32'hCAFE_F00D, 32'h0,
                     1'b1, 1'b0, 2'b00, 1'b0, 5'd17, 5'd16,
                     1'b1, 32'hA5A5_0003, 32'hA5A5_0003, 32'hCAFE_F00D};
        vecs[10] = '{32'h0000_0020, 5'd9,  32'hDEAD_BEEF, 32'h0,         32'h0,
                     1'b1, 1'b0, 2'b00, 1'b0, 5'd9,  5'd9,
                     1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[11] = '{32'h0C00_0000, 5'd31, 32'h55,        32'h1111_1111, 32'h0000_3004,
                     1'b1, 1'b1, 2'b01, 1'b0, 5'd31, 5'd9,
                     1'b1, 32'h0000_3008, 32'h0000_3008, 32'hDEAD_BEEF};
        vecs[12] = '{32'h0000_0009, 5'd30, 32'h55,        32'h0,         32'hFFFF_FFFC,
                     1'b1, 1'b0, 2'b10, 1'b0, 5'd30, 5'd31,
                     1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_3008};
        vecs[13] = '{32'h0000_0020, 5'd29, 32'h777,       32'h0,         32'h0000_5000,
                     1'b1, 1'b0, 2'b11, 1'b0, 5'd29, 5'd30,
                     1'b1, 32'h0000_0777, 32'h0000_0777, 32'h0};
        vecs[14] = '{32'h0000_0020, 5'd0,  32'h7,         32'h0,         32'h0,
                     1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  5'd29,
                     1'b0, 32'h0000_0007, 32'h0,          32'h0000_0777};
        vecs[15] = '{32'h8C04_0000, 5'd4,  32'h7,         32'h0,         32'h0,
                     1'b1, 1'b0, 2'b00, 1'b1, 5'd4,  5'd17,
                     1'b0, 32'h0000_0007, 32'h0,          32'hA5A5_0003};
        vecs[16] = '{32'h0000_0000, 5'd4,  32'h99,        32'h0,         32'h0,
                     1'b0, 1'b0, 2'b00, 1'b0, 5'd4,  5'd9,
                     1'b0, 32'h0000_0099, 32'h0,          32'hDEAD_BEEF};
        vecs[17] = '{32'h0C00_0000, 5'd0,  32'h0,         32'h0,         32'h0000_0100,
                     1'b1, 1'b0, 2'b01, 1'b0, 5'd0,  5'd5,
                     1'b0, 32'h0000_0104, 32'h0,          32'h0000_1234};
        vecs[18] = '{32'h0000_0020, 5'd8,  32'h1,         32'h0,         32'h0,
                     1'b0, 1'b0, 2'b00, 1'b0, 5'd8,  5'd14,
                     1'b0, 32'h0000_0001, 32'h0000_0080, 32'h0000_007F};

        // Reset held across an edge with a pending write: nothing lands.
        reset = 1'b0;
        apply('{32'h0000_0020, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0,
                5'd5, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0});
        @(negedge clk);
        step();
        reg_write = 1'b0;
        #1;
        chk("reset.rd1", rd1, 32'h0);
        chk("reset.retired", retired, 32'd0);
        chk("reset.wrap_retired", {29'd0, w_retired}, 32'd0);

        // Release reset and repeat the write.
        reset     = 1'b1;
        reg_write = 1'b1;
        step();
        reg_write = 1'b0;
        #1;
        chk("first_write.rd1", rd1, 32'h0000_1234);
        chk("first_write.retired", retired, 32'd1);

        // Table vectors: expected outputs queued at drive, popped after settling.
        for (int i = 0; i < NumVec; i++) begin
            apply(vecs[i]);
            sb.push_back('{vecs[i].we, vecs[i].wd, vecs[i].rd1, vecs[i].rd2});
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d.we", i), {31'd0, wb_we}, {31'd0, e.we});
            chk($sformatf("v%0d.wd", i), wb_wd, e.wd);
            chk($sformatf("v%0d.rd1", i), rd1, e.rd1);
            chk($sformatf("v%0d.rd2", i), rd2, e.rd2);
            step();
        end
        chk("table.retired", retired, exp_ret);

        // Cancelled load: no register change, no retire.
        apply('{32'h8C04_0000, 5'd4, 32'h7, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1,
                5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0});
        step();
        away      = 1'b0;
        reg_write = 1'b0;
        ir        = 32'd0;
        ra1       = 5'd4;
        #1;
        chk("away.rd1", rd1, 32'h0);
        chk("away.retired", retired, exp_ret);

        // Narrow counter: nine retires with bubbles between them wraps to 1.
        for (int k = 1; k <= 9; k++) begin
            w_ir = 32'h0000_0020 + k;
            step();
            w_ir = 32'd0;
            step();
            if (k == 7) chk("wrap.at7", {29'd0, w_retired}, 32'd7);
            if (k == 8) chk("wrap.at8", {29'd0, w_retired}, 32'd0);
        end
        chk("wrap.final", {29'd0, w_retired}, 32'd1);

        // Asynchronous reset mid-cycle clears state without a clock edge.
        ra1 = 5'd9;
        ra2 = 5'd31;
        #2;
        reset = 1'b0;
        #1;
        chk("async.rd1", rd1, 32'h0);
        chk("async.rd2", rd2, 32'h0);
        chk("async.retired", retired, 32'd0);
        chk("async.wrap_retired", {29'd0, w_retired}, 32'd0);

        // Write attempted during reset is discarded.
        @(negedge clk);
        apply('{32'h0000_0020, 5'd20, 32'h55, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0,
                5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0});
        step();
        reg_write = 1'b0;
        ir        = 32'd0;
        ra1       = 5'd20;
        reset     = 1'b1;
        #1;
        chk("reset_discard.rd1", rd1, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register bundle.
- Takes the latched MEM/WB fields and selects the write-back value: ALU result, extended load data, or link address.
- Owns the 32x32 general register file, with two read ports and write-through bypass to the decode stage.
- Keeps a retired-instruction counter for the bench and for debug.

Parameters:
- RET_W, 32, width of the retired-instruction counter.
- LINK_OFS, 4, value added to PCp4 to form the link address (skips the delay slot).

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears the register file and the counter.
- IR  in  32  MEM/WB instruction word; opcode is IR[31:26].
- A3  in  5  destination register.
- AO  in  32  ALU result / memory address.
- DR  in  32  raw word read from data memory.
- PCp4  in  32  instruction PC+4.
- RegWrite  in  1  write enable.
- MemtoReg  in  1  1 = write load data.
- Link  in  2  00 = none, 01 = jal, 10 = jalr, 11 = reserved (treated as none).
- AWAY  in  1  1 = instruction cancelled; suppress all architectural effect.
- RA1  in  5  read address, port 1.
- RA2  in  5  read address, port 2.
- RD1  out  32  read data, port 1 (combinational).
- RD2  out  32  read data, port 2 (combinational).
- WB_WE  out  1  effective write enable this cycle (combinational).
- WB_WD  out  32  selected write-back data (combinational).
- RETIRED  out  RET_W  count of retired instructions.

Behaviour:
- Reset: asynchronous and active-low, independent of CLK.
  - While reset=0: all 32 registers = 0 and RETIRED = 0.
  - Reset asserted mid-operation discards any in-flight write.
  - First write is possible at the first rising CLK edge after reset=1.
- Write-back data select, priority order:
  - Link != 00 and Link != 11 -> WB_WD = PCp4 + LINK_OFS (mod 2^32).
  - else MemtoReg=1 -> WB_WD = extended load data.
  - else -> WB_WD = AO.
- Load extension, selected by IR[31:26] using byte lane AO[1:0] (little-endian):
  - 0x23 lw -> DR.
  - 0x20 lb -> sign-extended DR[8*AO[1:0]+7 : 8*AO[1:0]].
  - 0x24 lbu -> zero-extended byte, same lane.
  - 0x21 lh -> sign-extended DR[16*AO[1]+15 : 16*AO[1]]; AO[0] ignored (alignment is checked upstream).
  - 0x25 lhu -> zero-extended halfword, same lane.
  - any other opcode with MemtoReg=1 -> DR unchanged.
- Write enable: WB_WE = RegWrite & ~AWAY & (A3 != 0).
  - On a rising CLK edge with WB_WE=1, register[A3] <= WB_WD.
  - Register 0 always reads 0 and is never written.
- Reads are combinational with bypass:
  - RDn = 0 if RAn = 0.
  - else WB_WD if WB_WE and RAn = A3 (same-cycle write visible to the reader).
  - else register[RAn].
  - Both ports may hit the same address or bypass simultaneously.
- Retire counter:
  - RETIRED increments by 1 on each rising edge with IR != 0 and AWAY = 0, whether or not the instruction writes a register.
  - Wraps from 2^RET_W-1 to 0 with no flag.
- Latency:
  - Register write is visible in the array one cycle after the edge.
  - Through bypass, the written value is visible in the same cycle.
- Link with A3 = 0, or AWAY=1 together with any other field: no write, and WB_WE = 0.

Test Plan:
- Hold reset=0 across a CLK edge with RegWrite=1, A3=5, AO=0x1234 -> RD1(RA1=5) = 0, RETIRED = 0. Release reset, repeat the write -> next cycle RD1 = 0x00001234, RETIRED = 1.
- lb: IR opcode 0x20, MemtoReg=1, DR=0x80FF7F01, AO[1:0]=3, A3=8 -> WB_WD = 0xFFFFFF80. Same with lbu -> 0x00000080. lh, AO[1]=1 -> 0xFFFF80FF. lhu -> 0x000080FF.
- Bypass: RegWrite=1, A3=9, AO=0xDEADBEEF, RA1=RA2=9 in the same cycle -> RD1 = RD2 = 0xDEADBEEF before the edge. After the edge, with RegWrite=0, reads still return 0xDEADBEEF.
- jal: Link=01, PCp4=0x00003004, A3=31, RegWrite=1, MemtoReg=1 -> WB_WD = 0x00003008 (Link overrides MemtoReg), and register 31 = 0x00003008.
- Suppression:
  - RegWrite=1, A3=0, AO=7 -> RD1(RA1=0) = 0, WB_WE = 0.
  - AWAY=1, A3=4, AO=7, IR=0x8C040000 -> register 4 is unchanged and RETIRED does not increment.
- Counter wrap: instantiate with RET_W=3, retire 9 non-NOP instructions (IR != 0) -> RETIRED = 1. Interleave IR=0 bubbles -> bubbles are not counted.
